morse_encoder: RTL and testbench
================================

Name: morse_encoder

Overview:
- Transmit-side counterpart of the Morse decoder path: accepts one character code per handshake and drives a keyed line (key_out) with standard Morse timing.
- Timing derives from an internal unit prescaler that counts CLK cycles. The decoder-side comparator/divider chain is the matching receive-side timer.
- Sits between the character source (switches/UART/test ROM) and the LED/buzzer/loopback to the decoder.

Parameters:
- UNIT_CYCLES, 50: CLK cycles per Morse time unit; legal range 2 or more.
- CW, $clog2(UNIT_CYCLES): prescaler counter width (derived; do not override).

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST  in  1  reset; asynchronous, active-high.
- char_in  in  5  character code: 0–25 = A–Z, 26 = word space, 27–31 invalid.
- start  in  1  request; accepted only in a cycle where ready=1.
- ready  out  1  high in IDLE only.
- key_out  out  1  keyed line: 1 = tone/mark, 0 = space.
- done  out  1  one-cycle pulse in the last cycle of a character (including word space).
- err  out  1  one-cycle pulse the cycle after an invalid code is accepted.

Behaviour:
- Reset (async, any state, including mid-element):
  - key_out=0, done=0, err=0, ready=1.
  - State=IDLE; prescaler=0; element index=0; unit count=0.
- Unit tick:
  - Prescaler counts 0..UNIT_CYCLES-1, then wraps to 0. Tick = prescaler at UNIT_CYCLES-1.
  - Prescaler is held at 0 in IDLE and restarts at 0 on accept, so every unit is exactly UNIT_CYCLES cycles.
- Lookup (combinational):
  - char_in maps to len (3 bits, 1–4) and pat (4 bits). Elements are sent pat[len-1] down to pat[0].
  - Pattern bit 1 = dash, 0 = dot.
  - Example: A gives len=2, pat=0001 (dot, dash).
- Accept:
  - On a rising edge with start & ready, the code, len and pat are registered.
  - start while ready=0 is ignored (no queueing).
- States:
  - IDLE:
    - Valid letter → MARK.
    - Code 26 → WORD.
    - Invalid code → stay in IDLE, err=1 next cycle, ready stays 1.
  - MARK:
    - key_out=1 for 1 unit (dot) or 3 units (dash).
    - On the final unit tick: more elements remain → ELEM_GAP; otherwise → CHAR_GAP.
  - ELEM_GAP: key_out=0 for 1 unit, then → MARK with the next element.
  - CHAR_GAP: key_out=0 for 3 units. done=1 in its final cycle; → IDLE.
  - WORD:
    - key_out=0 for 4 units. This plus the preceding 3-unit char gap gives a 7-unit word gap.
    - done=1 in its final cycle; → IDLE.
- Latency:
  - key_out goes high in the first cycle after the accept edge.
  - ready returns high the cycle after done.
  - Busy cycles per letter = UNIT_CYCLES × (sum of element units + (len-1) + 3).
- key_out is a registered output; no combinational path from inputs to outputs.
- Unit counter (2 bits) counts ticks within the current phase and resets at every phase change.

Decomposition:
- Shared package morse_pkg holds:
  - state enum: IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD;
  - constants DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_EXTRA_UNITS=4, CODE_SPACE=26;
  - the 26-entry len/pat table, shared with the decoder's match logic.
- One sub-module, morse_lut: combinational char_in to {valid, len, pat}. The FSM and prescaler stay in morse_encoder.

Test Plan:
- Case E (code 4), UNIT_CYCLES=4: start pulsed 1 cycle → key_out high 4 cycles, then low 12 cycles; done on cycle 16 after accept; ready=1 on cycle 17.
- Case A (code 0), UNIT_CYCLES=4 → key_out high 4, low 4, high 12, low 12 cycles; done on cycle 32; exactly 2 rising edges on key_out.
- Case Q (code 16, dash-dash-dot-dash), UNIT_CYCLES=4 → high 12/low 4/high 12/low 4/high 4/low 4/high 12, then low 12; done at cycle 64.
- Case space and invalid code:
  - Code 26 → key_out stays 0 for 16 cycles, done at cycle 16.
  - Code 29 → err pulse 1 cycle after accept; key_out 0, ready stays 1, no done.
- Case start while busy: start held high throughout a T (code 19) transmission → exactly one character sent (high 12, low 12). A second transmission begins the cycle after ready re-asserts, since start is still high.
- Case reset mid-dash: RST asserted asynchronously (between edges) during the T mark → key_out, done and err go 0 immediately, ready goes 1 immediately. After deassert, a new E transmits with correct 4-cycle timing.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, phase lengths in units, and the A-Z element table.
// The table is also consumed by the receive-side match logic.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ELEM_GAP,
        CHAR_GAP,
        WORD
    } state_t;

    localparam logic [2:0] DOT_UNITS        = 3'd1;
    localparam logic [2:0] DASH_UNITS       = 3'd3;
    localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
    localparam logic [2:0] CHAR_GAP_UNITS   = 3'd3;
    localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;
    localparam logic [4:0] CODE_SPACE       = 5'd26;
    localparam int         NUM_LETTERS      = 26;

    typedef struct packed {
        logic [2:0] len;
        logic [3:0] pat;
    } morse_entry_t;

    // pat is read from bit len-1 down to bit 0; 1 = dash, 0 = dot.
    localparam morse_entry_t MORSE_TABLE [NUM_LETTERS] = '{
        '{3'd2, 4'b0001},  // A .-
        '{3'd4, 4'b1000},  // B -...
        '{3'd4, 4'b1010},  // C -.-.
        '{3'd3, 4'b0100},  // D -..
        '{3'd1, 4'b0000},  // E .
        '{3'd4, 4'b0010},  // F ..-.
        '{3'd3, 4'b0110},  // G --.
        '{3'd4, 4'b0000},  // H ....
        '{3'd2, 4'b0000},  // I ..
        '{3'd4, 4'b0111},  // J .---
        '{3'd3, 4'b0101},  // K -.-
        '{3'd4, 4'b0100},  // L .-..
        '{3'd2, 4'b0011},  // M --
        '{3'd2, 4'b0010},  // N -.
        '{3'd3, 4'b0111},  // O ---
        '{3'd4, 4'b0110},  // P .--.
        '{3'd4, 4'b1101},  // Q --.-
        '{3'd3, 4'b0010},  // R .-.
        '{3'd3, 4'b0000},  // S ...
        '{3'd1, 4'b0001},  // T -
        '{3'd3, 4'b0001},  // U ..-
        '{3'd4, 4'b0001},  // V ...-
        '{3'd3, 4'b0011},  // W .--
        '{3'd4, 4'b1001},  // X -..-
        '{3'd4, 4'b1011},  // Y -.--
        '{3'd4, 4'b1100}   // Z --..
    };

endpackage

// File: rtl/morse_lut.sv
// Combinational character lookup: letter code to {valid, len, pat}.
// Word space and codes 27-31 report valid=0 with len/pat cleared.
module morse_lut
    import morse_pkg::*;
(
    input  logic [4:0] char_in,
    output logic       valid,
    output logic [2:0] len,
    output logic [3:0] pat
);

    logic [NUM_LETTERS-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LETTERS; gi++) begin : g_hit
            assign hit[gi] = (char_in == 5'(gi));
        end
    endgenerate

    always_comb begin
        valid = |hit;
        len   = '0;
        pat   = '0;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (hit[i]) begin
                len = MORSE_TABLE[i].len;
                pat = MORSE_TABLE[i].pat;
            end
        end
    end

endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: one character per start/ready handshake, keyed output timed
// in units of UNIT_CYCLES clocks by an internal prescaler.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 50
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] char_in,
    input  logic       start,
    output logic       ready,
    output logic       key_out,
    output logic       done,
    output logic       err
);

    localparam int CW = $clog2(UNIT_CYCLES);

    logic          lut_valid;
    logic [2:0]    lut_len;
    logic [3:0]    lut_pat;

    state_t        state_reg;
    logic [CW-1:0] prescale_reg;
    logic [1:0]    unit_cnt_reg;
    logic [1:0]    idx_reg;
    logic [3:0]    pat_reg;
    logic          key_reg;
    logic          done_reg;
    logic          err_reg;
    logic          ready_reg;

    logic          tick;
    logic [2:0]    phase_units;
    logic          unit_last;
    logic          phase_end;
    logic          done_next;

    morse_lut u_lut (
        .char_in (char_in),
        .valid   (lut_valid),
        .len     (lut_len),
        .pat     (lut_pat)
    );

    assign tick = (prescale_reg == CW'(UNIT_CYCLES - 1));

    always_comb begin
        phase_units = ELEM_GAP_UNITS;
        case (state_reg)
            MARK:     phase_units = pat_reg[idx_reg] ? DASH_UNITS : DOT_UNITS;
            ELEM_GAP: phase_units = ELEM_GAP_UNITS;
            CHAR_GAP: phase_units = CHAR_GAP_UNITS;
            WORD:     phase_units = WORD_EXTRA_UNITS;
            default:  phase_units = ELEM_GAP_UNITS;
        endcase
    end

    assign unit_last = ({1'b0, unit_cnt_reg} == (phase_units - 3'd1));
    assign phase_end = tick && unit_last;
    // done is registered, so raise it one cycle ahead of the phase's final tick.
    assign done_next = ((state_reg == CHAR_GAP) || (state_reg == WORD)) && unit_last
                       && (prescale_reg == CW'(UNIT_CYCLES - 2));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= IDLE;
            prescale_reg <= '0;
            unit_cnt_reg <= '0;
            idx_reg      <= '0;
            pat_reg      <= '0;
            key_reg      <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            ready_reg    <= 1'b1;
        end else begin
            done_reg <= done_next;
            err_reg  <= 1'b0;
            if (state_reg == IDLE) begin
                prescale_reg <= '0;
                unit_cnt_reg <= '0;
                if (start && ready_reg) begin
                    if (lut_valid) begin
                        state_reg <= MARK;
                        pat_reg   <= lut_pat;
                        idx_reg   <= 2'(lut_len - 3'd1);
                        key_reg   <= 1'b1;
                        ready_reg <= 1'b0;
                    end else if (char_in == CODE_SPACE) begin
                        state_reg <= WORD;
                        ready_reg <= 1'b0;
                    end else begin
                        err_reg <= 1'b1;
                    end
                end
            end else begin
                prescale_reg <= tick ? '0 : prescale_reg + 1'b1;
                if (tick) begin
                    unit_cnt_reg <= unit_last ? 2'd0 : unit_cnt_reg + 2'd1;
                end
                if (phase_end) begin
                    if (state_reg == MARK) begin
                        key_reg <= 1'b0;
                        if (idx_reg != 2'd0) begin
                            state_reg <= ELEM_GAP;
                            idx_reg   <= idx_reg - 2'd1;
                        end else begin
                            state_reg <= CHAR_GAP;
                        end
                    end else if (state_reg == ELEM_GAP) begin
                        state_reg <= MARK;
                        key_reg   <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign key_out = key_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign ready   = ready_reg;

endmodule

// File: tb/tb_morse_encoder.sv
// Randomized and directed bench for morse_encoder; expected keying is built
// from dot/dash strings and unit rules, one line printed per transaction.
module tb_morse_encoder;

    localparam int UC = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] char_in = '0;
    logic       start = 1'b0;
    logic       ready;
    logic       key_out;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    string morse [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                          "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                          "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                          "-.--", "--.."};

    bit exp_key[$];

    always #5 CLK = ~CLK;

    morse_encoder #(.UNIT_CYCLES(UC)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .char_in (char_in),
        .start   (start),
        .ready   (ready),
        .key_out (key_out),
        .done    (done),
        .err     (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected key level for each cycle after the accept edge.
    task automatic build(input int code, output int elems);
        exp_key.delete();
        elems = 0;
        if (code == 26) begin
            repeat (7 * UC - 3 * UC) exp_key.push_back(1'b0);
        end else begin
            string s = morse[code];
            elems = s.len();
            for (int i = 0; i < s.len(); i++) begin
                int units = (s[i] == "-") ? 3 : 1;
                repeat (units * UC) exp_key.push_back(1'b1);
                if (i != s.len() - 1) repeat (UC) exp_key.push_back(1'b0);
            end
            repeat (3 * UC) exp_key.push_back(1'b0);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (ready !== 1'b1) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input int code, input int exp_done, input string name);
        int n, elems, key_bad, rises, done_at, done_cnt, busy_bad, errs;
        bit prev;
        prev = 1'b0; key_bad = 0; rises = 0; done_at = -1; done_cnt = 0; busy_bad = 0; errs = 0;
        build(code, elems);
        n = exp_key.size();
        if (exp_done < 0) exp_done = n;
        wait_ready();
        @(negedge CLK);
        char_in = code[4:0];
        start   = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge CLK);
            start = 1'b0;
            if (k <= n) begin
                if (key_out !== exp_key[k-1]) key_bad++;
                if (key_out === 1'b1 && !prev) rises++;
                prev = (key_out === 1'b1);
                if (ready !== 1'b0) busy_bad++;
            end else begin
                check({name, "_ready_after"}, ready, 1);
                check({name, "_key_after"}, key_out, 0);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (err !== 1'b0) errs++;
        end
        check({name, "_key_mismatch_cycles"}, key_bad, 0);
        check({name, "_done_cycle"}, done_at, exp_done);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_ready_low_busy"}, busy_bad, 0);
        check({name, "_rising_edges"}, rises, elems);
        check({name, "_err"}, errs, 0);
        $display("txn %s code=%0d cycles=%0d done_at=%0d rises=%0d key_bad=%0d",
                 name, code, n, done_at, rises, key_bad);
    endtask

    task automatic send_invalid(input int code);
        int errs, dones, key_hi, ready_lo, err_first;
        errs = 0; dones = 0; key_hi = 0; ready_lo = 0; err_first = 0;
        wait_ready();
        @(negedge CLK);
        char_in = code[4:0];
        start   = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            start = 1'b0;
            if (k == 1) err_first = (err === 1'b1) ? 1 : 0;
            if (err === 1'b1) errs++;
            if (done !== 1'b0) dones++;
            if (key_out !== 1'b0) key_hi++;
            if (ready !== 1'b1) ready_lo++;
        end
        check("inv_err_cycle1", err_first, 1);
        check("inv_err_pulses", errs, 1);
        check("inv_no_done", dones, 0);
        check("inv_key_low", key_hi, 0);
        check("inv_ready_high", ready_lo, 0);
        $display("txn invalid code=%0d err_pulses=%0d ready_low=%0d", code, errs, ready_lo);
    endtask

    task automatic send_held_t();
        int n, elems, key_bad, done_at, ready_at, key2, ready2, cnt;
        key_bad = 0; done_at = -1; ready_at = 0; key2 = 0; ready2 = 1;
        build(19, elems);
        n = exp_key.size();
        wait_ready();
        @(negedge CLK);
        char_in = 5'd19;
        start   = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge CLK);
            if (k <= n && key_out !== exp_key[k-1]) key_bad++;
            if (done === 1'b1 && done_at < 0) done_at = k;
            if (k == n + 1) ready_at = (ready === 1'b1) ? 1 : 0;
            if (k == n + 2) begin
                key2   = (key_out === 1'b1) ? 1 : 0;
                ready2 = (ready === 1'b1) ? 1 : 0;
            end
        end
        start = 1'b0;
        check("held_key_mismatch_cycles", key_bad, 0);
        check("held_done_cycle", done_at, n);
        check("held_ready_after_done", ready_at, 1);
        check("held_second_key_high", key2, 1);
        check("held_second_ready_low", ready2, 0);
        cnt = 0;
        while (done !== 1'b1 && cnt < 1000) begin
            @(negedge CLK);
            cnt++;
        end
        check("held_second_done_seen", done, 1);
        wait_ready();
        $display("txn held_start code=19 done_at=%0d second_started=%0d", done_at, key2);
    endtask

    task automatic reset_mid_dash();
        wait_ready();
        @(negedge CLK);
        char_in = 5'd19;
        start   = 1'b1;
        @(posedge CLK);
        repeat (5) begin
            @(negedge CLK);
            start = 1'b0;
        end
        check("rst_pre_key_high", key_out, 1);
        #2 RST = 1'b1;
        #1;
        check("rst_key", key_out, 0);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        #1 RST = 1'b0;
        $display("txn reset_mid_dash key=%0d ready=%0d", key_out, ready);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_key", key_out, 0);
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        @(negedge CLK);
        RST = 1'b0;
        $display("txn reset key=%0d ready=%0d done=%0d err=%0d", key_out, ready, done, err);

        send(4, 16, "E");
        send(0, 32, "A");
        send(16, 64, "Q");
        send(26, 16, "SPACE");
        send_invalid(29);
        send_held_t();
        reset_mid_dash();
        send(4, 16, "E_after_rst");

        for (int i = 0; i < 14; i++) begin
            int r = $urandom_range(0, 31);
            if (r <= 26) send(r, -1, $sformatf("rnd%0d", i));
            else         send_invalid(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
